serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor computing `a - b` one bit per clock, LSB first, with a single full-subtractor cell and a borrow flop. It is the inverse-operation companion to the board-level full-adder demo. It takes operands from the switch bank, and its result and borrow drive the LED bank. A start/busy/done handshake lets the top level trigger it from a debounced button.

---
 rtl/serial_subtractor.sv | 97 +++++++++
 tb/tb_serial_subtractor.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell plus a borrow flop,
// LSB first, with a start/busy/done handshake and held result registers.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa, sb, sr;
    logic             bor;
    logic [CW-1:0]    cnt;

    logic             d, bnext;
    logic [WIDTH-1:0] sr_next;

    // Shifting through a WIDTH+1 concatenation keeps WIDTH=1 free of a reversed slice.
    always_comb begin
        d       = sa[0] ^ sb[0] ^ bor;
        bnext   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bor);
        sr_next = WIDTH'({d, sr} >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sa         <= '0;
            sb         <= '0;
            sr         <= '0;
            bor        <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        bor   <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr  <= sr_next;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    bor <= bnext;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        diff       <= sr_next;
                        borrow_out <= bnext;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        bor   <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed + randomized bench for serial_subtractor (WIDTH=4) against an
// arithmetic reference: {borrow, diff} = {a < b, (a - b) mod 16}.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int unsigned passes = 0;
    int unsigned total  = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] ref_diff(input int unsigned x, input int unsigned y);
        return W'((x - y) % 16);
    endfunction

    function automatic logic ref_bor(input int unsigned x, input int unsigned y);
        return x < y;
    endfunction

    // Accepts an operation at the next edge and checks busy, done and the result timing.
    task automatic run_op(input int unsigned x, input int unsigned y, input bit full);
        a = W'(x); b = W'(y); start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (full) begin
                chk("busy_during", 32'(busy), 32'd1);
                chk("done_during", 32'(done), 32'd0);
            end
            tick();
        end
        chk("done_pulse", 32'(done), 32'd1);
        if (full) chk("busy_at_done", 32'(busy), 32'd0);
        chk("diff", 32'(diff), 32'(ref_diff(x, y)));
        chk("borrow", 32'(borrow_out), 32'(ref_bor(x, y)));
        tick();
        if (full) chk("done_cleared", 32'(done), 32'd0);
    endtask

    initial begin
        int unsigned ea, eb;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(9, 3, 1'b1);
        run_op(3, 9, 1'b1);
        run_op(15, 15, 1'b1);
        run_op(0, 1, 1'b1);

        // Start re-pulse and operand changes during SHIFT must be ignored.
        a = 4'd9; b = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 4'd15; b = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_busy", 32'(busy), 32'd1);
        tick();
        chk("ign_no_early_done", 32'(done), 32'd0);
        tick();
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_diff", 32'(diff), 32'd6);
        chk("ign_borrow", 32'(borrow_out), 32'd0);
        tick();
        chk("ign_single_done", 32'(done), 32'd0);
        chk("ign_idle_busy", 32'(busy), 32'd0);

        // Continuous start: one result every W+1 cycles, new operands taken in DONE.
        ea = $urandom_range(15); eb = $urandom_range(15);
        a = W'(ea); b = W'(eb); start = 1'b1;
        tick();
        for (int s = 0; s < 15; s++) begin
            if (s % 5 == 4) begin
                chk("bb_done", 32'(done), 32'd1);
                chk("bb_busy_low", 32'(busy), 32'd0);
                chk("bb_diff", 32'(diff), 32'(ref_diff(ea, eb)));
                chk("bb_borrow", 32'(borrow_out), 32'(ref_bor(ea, eb)));
                ea = $urandom_range(15); eb = $urandom_range(15);
                a = W'(ea); b = W'(eb);
            end else begin
                chk("bb_no_done", 32'(done), 32'd0);
                chk("bb_busy", 32'(busy), 32'd1);
            end
            if (s == 14) start = 1'b0;
            tick();
        end
        chk("bb_idle_busy", 32'(busy), 32'd0);
        chk("bb_idle_done", 32'(done), 32'd0);

        // Mid-SHIFT asynchronous reset clears everything immediately.
        a = 4'd12; b = 4'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_diff", 32'(diff), 32'd0);
        chk("mid_rst_borrow", 32'(borrow_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_rst_no_done", 32'(done), 32'd0);
            chk("post_rst_no_busy", 32'(busy), 32'd0);
        end
        run_op(12, 7, 1'b1);

        for (int i = 0; i < 20; i++)
            run_op($urandom_range(15), $urandom_range(15), 1'b1);

        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                run_op(x, y, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
